mem_access_ctrl: RTL

Data-memory access controller sitting between the LC-3b MEM stage and the L1 data cache port. It takes the MEM stage's decoded access request and runs the cache handshake (read/write strobes held until `dmem_resp`). It performs the two-access sequence for LDI/STI and steers byte lanes for LDB/STB. It stalls the pipeline until the access completes and returns the load data that the MEM stage forwards as `sr_data_in`.

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_access_ctrl_byte_lane.sv | 27 ++
 rtl/mem_access_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared LC-3b types used by the data-memory access path.
// Holds the controller state encoding and the write lane masks.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } mem_ctrl_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;

endpackage

// File: rtl/mem_access_ctrl_byte_lane.sv
// Byte lane steering between the 16-bit cache port and byte/word accesses.
// Purely combinational; no latency, no flow control.
module mem_byte_lane
  import lc3b_types::*;
(
  input  logic       a0,
  input  logic       is_byte,
  input  lc3b_word   wdata,
  input  lc3b_word   dmem_rdata,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata_out,
  output lc3b_word   rdata_out
);

  always_comb begin
    byte_enable = BE_WORD;
    wdata_out   = wdata;
    rdata_out   = dmem_rdata;
    if (is_byte) begin
      // Store byte is replicated so either lane carries it; the mask picks one.
      byte_enable = a0 ? BE_HI : BE_LO;
      wdata_out   = {wdata[7:0], wdata[7:0]};
      rdata_out   = {8'h00, (a0 ? dmem_rdata[15:8] : dmem_rdata[7:0])};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: LC-3b MEM stage to L1 data cache port.
// Latency: 2 cycles request-to-done_valid with immediate dmem_resp, +1 per wait cycle, +1 min for LDI/STI.
// Backpressure: stall held while an access is outstanding; strobes held until dmem_resp.
module mem_access_ctrl
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_indirect,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        stall,
  output logic        done_valid,
  output logic [15:0] rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp
);

  mem_ctrl_state_t state;
  lc3b_word        a_q;
  lc3b_word        wdata_q;
  lc3b_word        rdata_q;
  logic            byte_q;
  logic            read_q;
  logic            write_q;

  logic            access_req;
  logic            lane_is_byte;
  logic [1:0]      lane_be;
  lc3b_word        lane_wdata;
  lc3b_word        lane_rdata;

  assign access_req = req_valid & (req_read | req_write);

  // The pointer fetch of LDI/STI is always a full word, whatever the final width.
  assign lane_is_byte = byte_q & (state != IND);

  mem_byte_lane u_lane (
    .a0          (a_q[0]),
    .is_byte     (lane_is_byte),
    .wdata       (wdata_q),
    .dmem_rdata  (dmem_rdata),
    .byte_enable (lane_be),
    .wdata_out   (lane_wdata),
    .rdata_out   (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      byte_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access_req) begin
            a_q     <= req_addr;
            wdata_q <= req_wdata;
            byte_q  <= req_byte;
            read_q  <= req_read;
            write_q <= req_write;
            state   <= req_indirect ? IND : ACC;
          end
        end
        IND: begin
          if (dmem_resp) begin
            a_q   <= dmem_rdata;
            state <= ACC;
          end
        end
        ACC: begin
          if (dmem_resp) begin
            if (read_q) rdata_q <= lane_rdata;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem_read        = (state == IND) | ((state == ACC) & read_q);
  assign dmem_write       = (state == ACC) & write_q;
  assign dmem_address     = {a_q[15:1], 1'b0};
  assign dmem_byte_enable = lane_be;
  assign dmem_wdata       = lane_wdata;

  assign stall      = ((state == IDLE) & access_req) | (state == IND) | (state == ACC);
  assign done_valid = (state == DONE);
  assign rdata      = rdata_q;

endmodule
